// File: rtl/fxu_pkg.sv
// Shared FXU definitions: opcode encodings, default tag/data widths and the
// operand-needed mask used by decode and the reservation station.
// Mask bit positions: OPND_T = 0, OPND_A = 1, OPND_B = 2.
package fxu_pkg;

  localparam int unsigned TAGW_DEF = 4;
  localparam int unsigned DW_DEF   = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_MOVL = 4'b0101;
  localparam logic [3:0] OP_MOVH = 4'b0110;

  localparam int unsigned OPND_T = 0;
  localparam int unsigned OPND_A = 1;
  localparam int unsigned OPND_B = 2;

  // Which source operands an opcode actually consumes. Unknown opcodes need none.
  function automatic logic [2:0] fxu_opnd_needed(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:   m = 3'b110;
      OP_MOV:           m = 3'b010;
      OP_MOVL, OP_MOVH: m = 3'b001;
      default:          m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fxu_rs_operand.sv
// One stored operand of a reservation-station entry.
// The source (dispatch, younger neighbour, or itself) is chosen by the parent;
// this cell applies the CDB capture to that source and registers the result,
// which covers both wakeup of held/shifted entries and dispatch bypass.
//   clk_i, rst_ni             clock, async active-low reset
//   src_rdy/tag/val_i         candidate operand state for the next edge
//   cdb_valid/rob/value_i     result broadcast
//   rdy_o, tag_o, val_o       registered operand state
module fxu_rs_operand #(
  parameter int unsigned TAGW = 4,
  parameter int unsigned DW   = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            src_rdy_i,
  input  logic [TAGW-1:0] src_tag_i,
  input  logic [DW-1:0]   src_val_i,
  input  logic            cdb_valid_i,
  input  logic [TAGW-1:0] cdb_rob_i,
  input  logic [DW-1:0]   cdb_value_i,
  output logic            rdy_o,
  output logic [TAGW-1:0] tag_o,
  output logic [DW-1:0]   val_o
);

  logic            hit;
  logic            rdy_q, rdy_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [DW-1:0]   val_q, val_d;

  assign hit = ~src_rdy_i & cdb_valid_i & (src_tag_i == cdb_rob_i);

  always_comb begin
    rdy_d = src_rdy_i | hit;
    tag_d = src_tag_i;
    val_d = hit ? cdb_value_i : src_val_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q <= 1'b0;
      tag_q <= '0;
      val_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      tag_q <= tag_d;
      val_q <= val_d;
    end
  end

  assign rdy_o = rdy_q;
  assign tag_o = tag_q;
  assign val_o = val_q;

endmodule

// File: rtl/fxu_rs.sv
// FXU reservation station: shift-compacting queue (slot 0 oldest) of renamed
// instructions. Operands are captured from the CDB; the oldest fully-ready
// entry is issued each cycle onto registered iss_* outputs.
//   clk, rst_n, flush                    clock, async reset, sync flush
//   disp_*                               dispatch request / operands, disp_ready back-pressure
//   cdb_valid, cdb_rob, cdb_value        FXU result broadcast
//   iss_valid, iss_opcode, iss_rob,
//   iss_vt/va/vb, iss_imm                issue interface to the FXU
module fxu_rs
  import fxu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = TAGW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [3:0]      disp_opcode,
  input  logic [TAGW-1:0] disp_rob,
  input  logic            disp_t_rdy,
  input  logic            disp_a_rdy,
  input  logic            disp_b_rdy,
  input  logic [DW-1:0]   disp_t_val,
  input  logic [DW-1:0]   disp_a_val,
  input  logic [DW-1:0]   disp_b_val,
  input  logic [TAGW-1:0] disp_t_tag,
  input  logic [TAGW-1:0] disp_a_tag,
  input  logic [TAGW-1:0] disp_b_tag,
  input  logic [8:0]      disp_imm,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_rob,
  input  logic [DW-1:0]   cdb_value,
  output logic            iss_valid,
  output logic [3:0]      iss_opcode,
  output logic [TAGW-1:0] iss_rob,
  output logic [DW-1:0]   iss_vt,
  output logic [DW-1:0]   iss_va,
  output logic [DW-1:0]   iss_vb,
  output logic [8:0]      iss_imm
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [CW-1:0]   count_q, count_d, wr_idx;
  logic [3:0]      ent_op  [DEPTH];
  logic [TAGW-1:0] ent_rob [DEPTH];
  logic [8:0]      ent_imm [DEPTH];
  logic            opnd_rdy [DEPTH][3];
  logic [TAGW-1:0] opnd_tag [DEPTH][3];
  logic [DW-1:0]   opnd_val [DEPTH][3];

  logic [2:0]      disp_need;
  logic            d_rdy [3];
  logic [TAGW-1:0] d_tag [3];
  logic [DW-1:0]   d_val [3];

  logic [DEPTH-1:0] elig, take_disp, take_up;
  logic [IW-1:0]    sel;
  logic             issue, accept;

  logic            iss_valid_q;
  logic [3:0]      iss_op_q;
  logic [TAGW-1:0] iss_rob_q;
  logic [DW-1:0]   iss_vt_q, iss_va_q, iss_vb_q;
  logic [8:0]      iss_imm_q;

  // Operands the opcode does not consume are stored ready so they never block select.
  assign disp_need    = fxu_opnd_needed(disp_opcode);
  assign d_rdy[OPND_T] = disp_t_rdy | ~disp_need[OPND_T];
  assign d_rdy[OPND_A] = disp_a_rdy | ~disp_need[OPND_A];
  assign d_rdy[OPND_B] = disp_b_rdy | ~disp_need[OPND_B];
  assign d_tag[OPND_T] = disp_t_tag;
  assign d_tag[OPND_A] = disp_a_tag;
  assign d_tag[OPND_B] = disp_b_tag;
  assign d_val[OPND_T] = disp_t_val;
  assign d_val[OPND_A] = disp_a_val;
  assign d_val[OPND_B] = disp_b_val;

  assign disp_ready = (count_q < CW'(DEPTH));
  assign accept     = disp_valid & disp_ready & ~flush;

  // Oldest-first select on registered readiness only.
  always_comb begin
    elig = '0;
    sel  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      elig[i] = (count_q > CW'(i)) & opnd_rdy[i][0] & opnd_rdy[i][1] & opnd_rdy[i][2];
      if (elig[i]) begin
        sel = IW'(i);
      end
    end
    issue = (|elig) & ~flush;
  end

  // When issuing, everything above the issued slot moves down one, so the
  // new entry lands one slot lower than the registered count.
  assign wr_idx = count_q - CW'(issue);

  always_comb begin
    take_disp = '0;
    take_up   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      take_disp[i] = accept & (wr_idx == CW'(i));
      take_up[i]   = issue & (i >= int'(sel)) & ~take_disp[i];
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(accept) - CW'(issue);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam int unsigned Up = (i < DEPTH - 1) ? i + 1 : i;

    logic [3:0]      op_q;
    logic [TAGW-1:0] rob_q;
    logic [8:0]      imm_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        op_q  <= '0;
        rob_q <= '0;
        imm_q <= '0;
      end else if (take_disp[i]) begin
        op_q  <= disp_opcode;
        rob_q <= disp_rob;
        imm_q <= disp_imm;
      end else if (take_up[i]) begin
        op_q  <= ent_op[Up];
        rob_q <= ent_rob[Up];
        imm_q <= ent_imm[Up];
      end
    end

    assign ent_op[i]  = op_q;
    assign ent_rob[i] = rob_q;
    assign ent_imm[i] = imm_q;

    for (genvar k = 0; k < 3; k++) begin : g_opnd
      logic            s_rdy;
      logic [TAGW-1:0] s_tag;
      logic [DW-1:0]   s_val;

      always_comb begin
        s_rdy = opnd_rdy[i][k];
        s_tag = opnd_tag[i][k];
        s_val = opnd_val[i][k];
        if (take_disp[i]) begin
          s_rdy = d_rdy[k];
          s_tag = d_tag[k];
          s_val = d_val[k];
        end else if (take_up[i]) begin
          s_rdy = opnd_rdy[Up][k];
          s_tag = opnd_tag[Up][k];
          s_val = opnd_val[Up][k];
        end
      end

      fxu_rs_operand #(
        .TAGW(TAGW),
        .DW  (DW)
      ) u_opnd (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .src_rdy_i  (s_rdy),
        .src_tag_i  (s_tag),
        .src_val_i  (s_val),
        .cdb_valid_i(cdb_valid),
        .cdb_rob_i  (cdb_rob),
        .cdb_value_i(cdb_value),
        .rdy_o      (opnd_rdy[i][k]),
        .tag_o      (opnd_tag[i][k]),
        .val_o      (opnd_val[i][k])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_rob_q   <= '0;
      iss_vt_q    <= '0;
      iss_va_q    <= '0;
      iss_vb_q    <= '0;
      iss_imm_q   <= '0;
    end else begin
      count_q     <= count_d;
      iss_valid_q <= issue;
      if (issue) begin
        iss_op_q  <= ent_op[sel];
        iss_rob_q <= ent_rob[sel];
        iss_vt_q  <= opnd_val[sel][OPND_T];
        iss_va_q  <= opnd_val[sel][OPND_A];
        iss_vb_q  <= opnd_val[sel][OPND_B];
        iss_imm_q <= ent_imm[sel];
      end
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_opcode = iss_op_q;
  assign iss_rob    = iss_rob_q;
  assign iss_vt     = iss_vt_q;
  assign iss_va     = iss_va_q;
  assign iss_vb     = iss_vb_q;
  assign iss_imm    = iss_imm_q;

endmodule
